// File: rtl/block_sync.sv
// 64b/66b block synchroniser: hunts for sync-header alignment by slipping the
// gearbox, declares block lock after a clean window and drops it on excess errors.
module block_sync #(
  parameter int GOOD_SH   = 64,
  parameter int BAD_SH    = 16,
  parameter int SLIP_WAIT = 32
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic [65:0] data_i,
  input  logic        data_vld_i,
  output logic [65:0] data_o,
  output logic        data_vld_o,
  output logic        slip_o,
  output logic        block_lock_o
);

  localparam int SH_W   = $clog2(GOOD_SH + 1);
  localparam int BAD_W  = $clog2(BAD_SH + 1);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [SH_W-1:0]   SH_LAST   = SH_W'(GOOD_SH);
  localparam logic [BAD_W-1:0]  BAD_LAST  = BAD_W'(BAD_SH);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SLIP_WAIT - 1);

  typedef enum logic {
    ST_TEST = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t            state;
  logic [SH_W-1:0]   sh_cnt;
  logic [BAD_W-1:0]  bad_cnt;
  logic [WAIT_W-1:0] wait_cnt;

  logic              hdr_ok;
  logic              eval;
  logic [SH_W-1:0]   sh_inc;
  logic [BAD_W-1:0]  bad_inc;
  logic              window_done;
  logic              bad_limit;

  // NOTE: every signal gets a value before any condition so no latch is inferred.
  always_comb begin
    hdr_ok      = data_i[1] ^ data_i[0];
    eval        = data_vld_i && (state == ST_TEST);
    sh_inc      = sh_cnt + SH_W'(1);
    bad_inc     = bad_cnt + BAD_W'(!hdr_ok);
    window_done = (sh_inc == SH_LAST);
    bad_limit   = (bad_inc == BAD_LAST);
  end

  // Lock/slip FSM; slip_o and block_lock_o are registered here with the state.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= ST_TEST;
      sh_cnt       <= '0;
      bad_cnt      <= '0;
      wait_cnt     <= '0;
      slip_o       <= 1'b0;
      block_lock_o <= 1'b0;
    end else begin
      slip_o <= 1'b0;
      case (state)
        ST_TEST: begin
          if (eval) begin
            if (!block_lock_o) begin
              if (!hdr_ok) begin
                slip_o   <= 1'b1;
                sh_cnt   <= '0;
                bad_cnt  <= '0;
                wait_cnt <= '0;
                state    <= ST_WAIT;
              end else if (window_done) begin
                block_lock_o <= 1'b1;
                sh_cnt       <= '0;
                bad_cnt      <= '0;
              end else begin
                sh_cnt <= sh_inc;
              end
            end else begin
              // Error limit wins over a window completing on the same block.
              if (bad_limit) begin
                block_lock_o <= 1'b0;
                slip_o       <= 1'b1;
                sh_cnt       <= '0;
                bad_cnt      <= '0;
                wait_cnt     <= '0;
                state        <= ST_WAIT;
              end else if (window_done) begin
                sh_cnt  <= '0;
                bad_cnt <= '0;
              end else begin
                sh_cnt  <= sh_inc;
                bad_cnt <= bad_inc;
              end
            end
          end
        end
        ST_WAIT: begin
          // Gearbox needs SLIP_WAIT cycles to realign; input is ignored meanwhile.
          if (wait_cnt == WAIT_LAST) begin
            wait_cnt <= '0;
            sh_cnt   <= '0;
            bad_cnt  <= '0;
            state    <= ST_TEST;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        default: state <= ST_TEST;
      endcase
    end
  end

  // Datapath register; the completing block sees the old lock and is not forwarded.
  // NOTE: data_o is reset too, so downstream never sees stale payload after reset.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_o     <= '0;
      data_vld_o <= 1'b0;
    end else begin
      if (data_vld_i) begin
        data_o <= data_i;
      end
      data_vld_o <= data_vld_i && block_lock_o;
    end
  end

  a_slip_single : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    slip_o |=> !slip_o);

  a_wait_unlocked : assert property (@(posedge clk_i) disable iff (!rst_n_i)
    (state == ST_WAIT) |-> !block_lock_o);

endmodule

// File: doc/block_sync.md
BLOCK_SYNC -- requirements
Module: block_sync

Interface
REQ-001 Parameter GOOD_SH, default 64, meaning consecutive-header window length for lock acquisition and for the locked test window.
REQ-002 Parameter BAD_SH, default 16, meaning invalid-header count within one window that drops lock.
REQ-003 Parameter SLIP_WAIT, default 32, meaning clock cycles ignored after each slip pulse, for gearbox realignment.
REQ-004 Port clk_i  input  1  rx clock, 156.25*2 MHz; one clock domain.
REQ-005 Port rst_n_i  input  1  reset; asynchronous, active-low.
REQ-006 Port data_i  input  66  gearbox block: [65:2] scrambled payload, [1:0] sync header.
REQ-007 Port data_vld_i  input  1  data_i holds a new block this cycle.
REQ-008 Port data_o  output  66  registered copy of data_i, feeding the descramble stage.
REQ-009 Port data_vld_o  output  1  data_o valid and block lock held.
REQ-010 Port slip_o  output  1  one-cycle request to the gearbox to shift alignment by one bit.
REQ-011 Port block_lock_o  output  1  block lock achieved.

Function
REQ-012 Valid header SHALL be data_i[1:0] equal to 2'b01 or 2'b10; 2'b00 and 2'b11 SHALL be invalid.
REQ-013 A block SHALL be evaluated only in a cycle with data_vld_i=1 and the FSM in TEST; all other cycles leave the counters unchanged.
REQ-014 FSM states SHALL be TEST and WAIT; counters sh_cnt (0..GOOD_SH, 7 bits at defaults), bad_cnt (0..BAD_SH, 5 bits), wait_cnt (0..SLIP_WAIT-1).
REQ-015 Each evaluated block SHALL increment sh_cnt; each evaluated block with an invalid header SHALL also increment bad_cnt.
REQ-016 Unlocked, invalid header: slip_o=1 next cycle, sh_cnt and bad_cnt cleared, go to WAIT.
REQ-017 Unlocked, valid header that brings sh_cnt to GOOD_SH: block_lock_o=1 at that same edge, both counters cleared, stay in TEST.
REQ-018 Locked, block that brings bad_cnt to BAD_SH: block_lock_o=0, slip_o=1 next cycle, counters cleared, go to WAIT; this takes priority over REQ-019 when both occur on the same block.
REQ-019 Locked, block that brings sh_cnt to GOOD_SH with bad_cnt below BAD_SH: both counters cleared, lock held.
REQ-020 WAIT SHALL last exactly SLIP_WAIT cycles, counted by wait_cnt, then return to TEST with cleared counters; data_vld_i SHALL be ignored in WAIT.
REQ-021 slip_o SHALL be high for exactly one cycle per slip event and never in two consecutive cycles.
REQ-022 data_o SHALL load data_i on every cycle with data_vld_i=1 and hold otherwise; latency one cycle.
REQ-023 data_vld_o SHALL be registered as data_vld_i AND block_lock_o, using block_lock_o's value before the edge; the block that completes lock is therefore not output.
REQ-024 No backpressure: the block SHALL accept data_vld_i every cycle with no ready signal.

Reset
REQ-025 While rst_n_i=0, asynchronously: data_o=66'h0, data_vld_o=0, slip_o=0, block_lock_o=0, state TEST, all counters 0.
REQ-026 Reset release SHALL take effect at the first clk_i edge after rst_n_i rises; reset mid-WAIT or mid-lock SHALL fully restart acquisition.

Verification
REQ-027 Send 64 blocks with header 2'b01 -> block_lock_o=1 after the 64th block's edge; data_vld_o first high for block 65; slip_o stays 0.
REQ-028 Send 10 valid blocks, then header 2'b11 -> slip_o high for one cycle, next 32 cycles of data_vld_i ignored, then count restarts at 0 and lock needs 64 more blocks.
REQ-029 When locked, send 15 invalid headers spread over 64 blocks -> lock held and counters cleared; then 16 invalid within the next 64 -> block_lock_o=0 and one slip_o pulse.
REQ-030 When locked, the 64th block is the 16th invalid header -> lock dropped and slip issued; the window-complete path is not taken.
REQ-031 Send data_vld_i with gaps (1 of every 3 cycles) and 64 valid headers -> lock after the 64th valid block; data_o holds during gaps.
REQ-032 Assert rst_n_i low mid-WAIT and while locked -> all outputs 0 immediately without a clock; acquisition restarts from 0 after release.
